sram_arbiter_2p: RTL and testbench

Two-port arbiter that shares the single 32-bit IS61WV25616 SRAM controller between two masters: port 0 for instruction fetch and port 1 for the LSU/debug loader.
- Accepts held-until-ack requests from each master and grants round-robin (or fixed priority).
- Issues a one-cycle command pulse to the controller and waits for the controller ack.
- Routes the ack and read data back to the owning master.
- Sits between the core memory masters and the SRAM controller; shares i_clk/i_reset with the controller.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_arbiter_2p_if.sv | 52 +++++
 rtl/rr_arbiter_2.sv | 17 +
 rtl/sram_arbiter_2p.sv | 104 ++++++++++
 tb/tb_sram_arbiter_2p.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and controller latency constants for the two-port SRAM arbiter.
package sram_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Command-to-ack latency of the IS61WV25616 controller, in cycles
  localparam int SRAM_WR_LAT  = 2;
  localparam int SRAM_RD_LAT  = 5;
  localparam int SRAM_DATA_W  = 32;
  localparam int SRAM_BMASK_W = 4;

endpackage

// File: rtl/sram_arbiter_2p_if.sv
// Bundle of both master ports plus the controller-facing command bus.
interface sram_arbiter_2p_if #(
  parameter int ADDR_W = 18
);
  import sram_pkg::*;

  logic                    i_m0_req;
  logic                    i_m0_we;
  logic [ADDR_W-1:0]       i_m0_addr;
  logic [SRAM_DATA_W-1:0]  i_m0_wdata;
  logic [SRAM_BMASK_W-1:0] i_m0_bmask;
  logic                    o_m0_ack;
  logic [SRAM_DATA_W-1:0]  o_m0_rdata;

  logic                    i_m1_req;
  logic                    i_m1_we;
  logic [ADDR_W-1:0]       i_m1_addr;
  logic [SRAM_DATA_W-1:0]  i_m1_wdata;
  logic [SRAM_BMASK_W-1:0] i_m1_bmask;
  logic                    o_m1_ack;
  logic [SRAM_DATA_W-1:0]  o_m1_rdata;

  logic [ADDR_W-1:0]       o_ADDR;
  logic [SRAM_DATA_W-1:0]  o_WDATA;
  logic [SRAM_BMASK_W-1:0] o_BMASK;
  logic                    o_WREN;
  logic                    o_RDEN;
  logic [SRAM_DATA_W-1:0]  i_RDATA;
  logic                    i_ACK;
  logic                    o_busy;

  // Arbiter side
  modport slave (
    input  i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata, i_m0_bmask,
    output o_m0_ack, o_m0_rdata,
    input  i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_bmask,
    output o_m1_ack, o_m1_rdata,
    output o_ADDR, o_WDATA, o_BMASK, o_WREN, o_RDEN, o_busy,
    input  i_RDATA, i_ACK
  );

  // Masters and controller side
  modport master (
    output i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata, i_m0_bmask,
    input  o_m0_ack, o_m0_rdata,
    output i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_bmask,
    input  o_m1_ack, o_m1_rdata,
    input  o_ADDR, o_WDATA, o_BMASK, o_WREN, o_RDEN, o_busy,
    output i_RDATA, i_ACK
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-requester grant logic: round-robin on ties, or fixed priority to port 0.
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       rr_en_i,
  output logic [1:0] grant_o
);

  // On a tie the port that was not served last wins; last_i resets to 1 so port 0 wins first
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = (rr_en_i && !last_i) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sram_arbiter_2p.sv
// Shares one SRAM controller between the fetch port (0) and the LSU/loader port (1).
module sram_arbiter_2p
  import sram_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter bit RR_EN  = 1'b1,
  parameter int DATA_W = 32
) (
  input logic              i_clk,
  input logic              i_reset,
  sram_arbiter_2p_if.slave bus
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       sel;
  logic       selValid;
  logic       issue;
  logic       ack0;
  logic       ack1;

  logic                    selWe;
  logic [ADDR_W-1:0]       selAddr;
  logic [DATA_W-1:0]       selWdata;
  logic [SRAM_BMASK_W-1:0] selBmask;

  assign req = {bus.i_m1_req, bus.i_m0_req};

  rr_arbiter_2 u_rr (
    .req_i   (req),
    .last_i  (last_q),
    .rr_en_i (RR_EN),
    .grant_o (grant)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Idle issues the winner's command combinationally; busy only waits for the controller ack
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    sel      = owner_q;
    selValid = 1'b0;
    issue    = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    case (state_q)
      StIdle: begin
        if (|grant) begin
          sel      = grant[1];
          selValid = 1'b1;
          issue    = 1'b1;
          state_d  = StBusy;
          owner_d  = grant[1];
          last_d   = grant[1];
        end
      end
      StBusy: begin
        selValid = 1'b1;
        if (bus.i_ACK) begin
          ack0    = !owner_q;
          ack1    = owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    selWe    = sel ? bus.i_m1_we    : bus.i_m0_we;
    selAddr  = sel ? bus.i_m1_addr  : bus.i_m0_addr;
    selWdata = sel ? bus.i_m1_wdata : bus.i_m0_wdata;
    selBmask = sel ? bus.i_m1_bmask : bus.i_m0_bmask;
  end

  // Everything is forced low while reset is held, even though the state only clears on the edge
  assign bus.o_ADDR     = (selValid && i_reset) ? selAddr  : '0;
  assign bus.o_WDATA    = (selValid && i_reset) ? selWdata : '0;
  assign bus.o_BMASK    = (selValid && i_reset) ? selBmask : '0;
  assign bus.o_WREN     = issue && i_reset && selWe;
  assign bus.o_RDEN     = issue && i_reset && !selWe;
  assign bus.o_m0_ack   = ack0 && i_reset;
  assign bus.o_m1_ack   = ack1 && i_reset;
  assign bus.o_m0_rdata = i_reset ? bus.i_RDATA : '0;
  assign bus.o_m1_rdata = i_reset ? bus.i_RDATA : '0;
  assign bus.o_busy     = (state_q == StBusy) && i_reset;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Scoreboard bench: two arbiter instances (round-robin and fixed priority) with an SRAM controller model each.
module tb_sram_arbiter_2p;
  import sram_pkg::*;

  localparam int AW      = 18;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          mReq   [2][2];
  logic          mWe    [2][2];
  logic [AW-1:0] mAddr  [2][2];
  logic [31:0]   mWdata [2][2];
  logic [3:0]    mBmask [2][2];
  logic          mAck   [2][2];
  logic [31:0]   mRdata [2][2];

  logic [AW-1:0] cAddr  [2];
  logic [31:0]   cWdata [2];
  logic [3:0]    cBmask [2];
  logic          cWren  [2];
  logic          cRden  [2];
  logic          cBusy  [2];
  logic          ctlAck [2];
  logic [31:0]   ctlRdata [2];
  logic          forceAck [2];

  exp_t        expQ [4][$];
  int          ackOrder [2][$];
  int          ackCount [2][2];
  logic [31:0] sramMem [int];
  logic [31:0] refMem [int];
  int          checks = 0;
  int          errors = 0;

  function automatic int memKey(int g, logic [AW-1:0] addr);
    return g * (1 << 20) + int'(addr[AW-1:1]);
  endfunction

  function automatic logic [31:0] initWord(int key);
    return 32'h5EED_0000 ^ 32'(key);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] bm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (bm[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] refGet(int key);
    if (refMem.exists(key)) return refMem[key];
    return initWord(key);
  endfunction

  function automatic logic [31:0] sramGet(int key);
    if (sramMem.exists(key)) return sramMem[key];
    return initWord(key);
  endfunction

  task automatic checkOutput(string name, int g, logic [95:0] actual, logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s inst%0d t=%0t: actual %0h, expected %0h", name, g, $time, actual, expected);
    end
  endtask

  // Issue one request and hold it until ack; called and returns one tick after a rising edge
  task automatic applyStimulus(int g, int p, logic we, logic [AW-1:0] addr, logic [31:0] wd, logic [3:0] bm);
    exp_t e;
    int   key;
    int   n;
    key = memKey(g, addr);
    e.we = we;
    if (we) begin
      refMem[key] = merge(refGet(key), wd, bm);
      e.rdata = '0;
    end else begin
      e.rdata = refGet(key);
    end
    expQ[g*2+p].push_back(e);
    mWe[g][p]    = we;
    mAddr[g][p]  = addr;
    mWdata[g][p] = wd;
    mBmask[g][p] = bm;
    mReq[g][p]   = 1'b1;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (mAck[g][p] !== 1'b1 && n < TIMEOUT);
    checkOutput($sformatf("ackWait_p%0d", p), g, 96'(mAck[g][p]), 96'd1);
    @(posedge i_clk); #1;
    mReq[g][p] = 1'b0;
  endtask

  task automatic doReset();
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    ackOrder[0].delete();
    ackOrder[1].delete();
  endtask

  task automatic checkOrder(string name, int g, int n, logic [15:0] pattern);
    logic [95:0] act;
    act = '0;
    act[95:88] = 8'(ackOrder[g].size());
    foreach (ackOrder[g][i]) if (i < 16) act[i] = (ackOrder[g][i] != 0);
    checkOutput(name, g, act, {8'(n), 72'd0, pattern});
  endtask

  task automatic randomPort(int g, int p, int count);
    logic [AW-1:0] a;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge i_clk);
      #1;
      a = {p[0], 12'h000, 5'($urandom)};
      applyStimulus(g, p, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam bit RR = (g == 0);

    sram_arbiter_2p_if #(.ADDR_W(AW)) bus ();

    sram_arbiter_2p #(.ADDR_W(AW), .RR_EN(RR), .DATA_W(32)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus.slave)
    );

    assign bus.i_m0_req   = mReq[g][0];
    assign bus.i_m0_we    = mWe[g][0];
    assign bus.i_m0_addr  = mAddr[g][0];
    assign bus.i_m0_wdata = mWdata[g][0];
    assign bus.i_m0_bmask = mBmask[g][0];
    assign bus.i_m1_req   = mReq[g][1];
    assign bus.i_m1_we    = mWe[g][1];
    assign bus.i_m1_addr  = mAddr[g][1];
    assign bus.i_m1_wdata = mWdata[g][1];
    assign bus.i_m1_bmask = mBmask[g][1];
    assign bus.i_ACK      = ctlAck[g];
    assign bus.i_RDATA    = ctlRdata[g];
    assign mAck[g][0]     = bus.o_m0_ack;
    assign mAck[g][1]     = bus.o_m1_ack;
    assign mRdata[g][0]   = bus.o_m0_rdata;
    assign mRdata[g][1]   = bus.o_m1_rdata;
    assign cAddr[g]       = bus.o_ADDR;
    assign cWdata[g]      = bus.o_WDATA;
    assign cBmask[g]      = bus.o_BMASK;
    assign cWren[g]       = bus.o_WREN;
    assign cRden[g]       = bus.o_RDEN;
    assign cBusy[g]       = bus.o_busy;

    // Controller model: latches a command and answers after the fixed latency; shares the reset
    initial begin : ctl
      int          cnt;
      int          key;
      logic [31:0] data;
      cnt = -1;
      data = '0;
      ctlAck[g] = 1'b0;
      ctlRdata[g] = '0;
      forever begin
        @(negedge i_clk);
        if (!i_reset) begin
          cnt = -1;
        end else if (cnt < 0 && (cWren[g] || cRden[g])) begin
          key = memKey(g, cAddr[g]);
          if (cWren[g]) begin
            sramMem[key] = merge(sramGet(key), cWdata[g], cBmask[g]);
            data = '0;
            cnt = SRAM_WR_LAT;
          end else begin
            data = sramGet(key);
            cnt = SRAM_RD_LAT;
          end
        end
        @(posedge i_clk); #1;
        if (cnt == 0) cnt = -1;
        else if (cnt > 0) cnt--;
        ctlAck[g]   = (cnt == 0) || forceAck[g];
        ctlRdata[g] = (cnt == 0) ? data : 32'h0;
      end
    end

    // Timing reference: one command per idle slot, ack at issue+latency, idle again right after
    initial begin : mon
      int         c;
      int         freeCyc;
      int         ackCyc;
      logic       owner;
      logic       last;
      logic       win;
      logic [1:0] expAck;
      exp_t       e;
      c = 0; freeCyc = 0; ackCyc = -1; owner = 1'b0; last = 1'b1;
      forever begin
        @(negedge i_clk);
        if (!i_reset) begin
          checkOutput("resetBus", g, 96'({cBusy[g], cWren[g], cRden[g], cAddr[g], cWdata[g], cBmask[g]}), 96'd0);
          checkOutput("resetPorts", g, 96'({mAck[g][1], mAck[g][0], mRdata[g][1], mRdata[g][0]}), 96'd0);
          freeCyc = c + 1;
          ackCyc = -1;
          last = 1'b1;
        end else begin
          expAck = 2'b00;
          if (c == ackCyc) expAck = owner ? 2'b10 : 2'b01;
          if (c >= freeCyc) begin
            if (mReq[g][0] || mReq[g][1]) begin
              win = (mReq[g][0] && mReq[g][1]) ? (RR ? !last : 1'b0) : mReq[g][1];
              checkOutput("command", g,
                96'({cBusy[g], cWren[g], cRden[g], cAddr[g], cWdata[g], cBmask[g]}),
                96'({1'b0, mWe[g][win], !mWe[g][win], mAddr[g][win], mWdata[g][win], mBmask[g][win]}));
              owner = win;
              last = win;
              ackCyc = c + (mWe[g][win] ? SRAM_WR_LAT : SRAM_RD_LAT);
              freeCyc = ackCyc + 1;
            end else begin
              checkOutput("idleQuiet", g, 96'({cBusy[g], cWren[g], cRden[g], cAddr[g], cWdata[g], cBmask[g]}), 96'd0);
            end
          end else begin
            checkOutput("busyHold", g,
              96'({cBusy[g], cWren[g], cRden[g], cAddr[g], cWdata[g], cBmask[g]}),
              96'({1'b1, 1'b0, 1'b0, mAddr[g][owner], mWdata[g][owner], mBmask[g][owner]}));
          end
          checkOutput("portAck", g, 96'({mAck[g][1], mAck[g][0]}), 96'(expAck));
          for (int p = 0; p < 2; p++) begin
            if (mAck[g][p] === 1'b1) begin
              ackOrder[g].push_back(p);
              ackCount[g][p]++;
              if (expQ[g*2+p].size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL ackWithoutRequest inst%0d port%0d t=%0t: actual ack 1, expected 0", g, p, $time);
              end else begin
                e = expQ[g*2+p].pop_front();
                if (!e.we) checkOutput($sformatf("readData_p%0d", p), g, 96'(mRdata[g][p]), 96'(e.rdata));
              end
            end
          end
        end
        c++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base0;
    int base1;
    int total;
    for (int g = 0; g < 2; g++) begin
      forceAck[g] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        mReq[g][p] = 1'b0; mWe[g][p] = 1'b0; mAddr[g][p] = '0;
        mWdata[g][p] = '0; mBmask[g][p] = '0; ackCount[g][p] = 0;
      end
    end
    i_reset = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b1;

    $display("[TB] port 0 write then port 1 read of the same word");
    applyStimulus(0, 0, 1'b1, 18'h00010, 32'hDEADBEEF, 4'hF);
    applyStimulus(0, 1, 1'b0, 18'h00010, 32'h0, 4'h0);
    checkOrder("writeThenRead", 0, 2, 16'b10);

    $display("[TB] simultaneous reads after reset");
    doReset();
    fork
      applyStimulus(0, 0, 1'b0, 18'h00010, 32'h0, 4'h0);
      applyStimulus(0, 1, 1'b0, 18'h20020, 32'h0, 4'h0);
    join
    checkOrder("tieAfterReset", 0, 2, 16'b10);

    $display("[TB] continuous requests, round-robin and fixed priority");
    doReset();
    base0 = ackCount[0][0];
    base1 = ackCount[0][1];
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1'(i % 2), 18'(18'h00200 + 4*i), $urandom, 4'hF);
      end
      begin
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1'((i + 1) % 2), 18'(18'h20200 + 4*i), $urandom, 4'h3);
      end
      begin
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1'b1, 18'(18'h00300 + 4*i), $urandom, 4'hF);
      end
      applyStimulus(1, 1, 1'b0, 18'h20300, 32'h0, 4'h0);
    join
    checkOrder("rrAlternate", 0, 8, 16'hAA);
    checkOutput("rrCountPort0", 0, 96'(ackCount[0][0] - base0), 96'd4);
    checkOutput("rrCountPort1", 0, 96'(ackCount[0][1] - base1), 96'd4);
    checkOrder("fixedPriority", 1, 5, 16'b10000);

    $display("[TB] reset in the middle of a read");
    mWe[0][0] = 1'b0; mAddr[0][0] = 18'h00010; mWdata[0][0] = '0; mBmask[0][0] = '0;
    mReq[0][0] = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    total = ackCount[0][0] + ackCount[0][1];
    i_reset = 1'b0;
    mReq[0][0] = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    repeat (8) @(posedge i_clk);
    #1;
    checkOutput("abandonedRead", 0, 96'(ackCount[0][0] + ackCount[0][1]), 96'(total));
    applyStimulus(0, 0, 1'b0, 18'h00010, 32'h0, 4'h0);

    $display("[TB] spurious controller ack while idle");
    total = ackCount[0][0] + ackCount[0][1] + ackCount[1][0] + ackCount[1][1];
    forceAck[0] = 1'b1;
    forceAck[1] = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    forceAck[0] = 1'b0;
    forceAck[1] = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("spuriousAck", 0, 96'(ackCount[0][0] + ackCount[0][1] + ackCount[1][0] + ackCount[1][1]), 96'(total));

    $display("[TB] randomized traffic on both instances");
    doReset();
    fork
      randomPort(0, 0, 12);
      randomPort(0, 1, 12);
      randomPort(1, 0, 12);
      randomPort(1, 1, 12);
    join
    repeat (10) @(posedge i_clk);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("queueDrained%0d", k), k / 2, 96'(expQ[k].size()), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
